// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one 16-bit byte-addressable RAM between the CPU and a DMA requester.
//   DMA normally wins. STARVE_LIMIT caps how many DMA grants in a row may pass
//   a waiting CPU; 0 gives DMA absolute priority. Each grant runs a single RAM
//   cycle (IDLE -> ACCESS -> ACK) and completes with a 4-phase req/ack handshake.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   cpu_req/addr/wdata/we/byte   CPU request and operands
//   cpu_ack, cpu_rdata  CPU handshake acknowledge and read data
//   dma_*               same set for the DMA requester
//   ram_a, ram_di       RAM byte address / write data
//   ram_do              RAM read data (combinational from ram_a)
//   ram_ce_n, ram_we_n  RAM chip enable / write enable, active low
//   ram_byte_op         RAM byte-op select
//   grant               owner of current/last transaction (0 = CPU, 1 = DMA)
//   busy                arbiter is not idle
module ram_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_byte,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    input  logic        dma_we,
    input  logic        dma_byte,
    output logic        dma_ack,
    output logic [15:0] dma_rdata,
    output logic [15:0] ram_a,
    output logic [15:0] ram_di,
    input  logic [15:0] ram_do,
    output logic        ram_ce_n,
    output logic        ram_we_n,
    output logic        ram_byte_op,
    output logic        grant,
    output logic        busy
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } state_t;

    state_t        state;
    logic [CW-1:0] starve_cnt;

    logic cpu_starved;
    logic dma_wins;
    logic winner_req;

    // A waiting CPU overrides DMA only once DMA has used up its run of grants.
    // grant already names the owner by the time we reach ACK.
    always_comb begin
        cpu_starved = cpu_req && (starve_cnt == LIMIT) && (STARVE_LIMIT != 0);
        dma_wins    = dma_req && !cpu_starved;
        winner_req  = grant ? dma_req : cpu_req;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            ram_a       <= '0;
            ram_di      <= '0;
            ram_byte_op <= 1'b0;
            ram_ce_n    <= 1'b1;
            ram_we_n    <= 1'b1;
            grant       <= 1'b0;
            busy        <= 1'b0;
            cpu_ack     <= 1'b0;
            dma_ack     <= 1'b0;
            cpu_rdata   <= '0;
            dma_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dma_wins) begin
                        ram_a       <= dma_addr;
                        ram_di      <= dma_wdata;
                        ram_byte_op <= dma_byte;
                        ram_we_n    <= ~dma_we;
                        ram_ce_n    <= 1'b0;
                        grant       <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ACCESS;
                        // Only grants that overtake a waiting CPU count toward starvation.
                        if (!cpu_req) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt != LIMIT) begin
                            starve_cnt <= starve_cnt + CW'(1);
                        end
                    end else if (cpu_req) begin
                        ram_a       <= cpu_addr;
                        ram_di      <= cpu_wdata;
                        ram_byte_op <= cpu_byte;
                        ram_we_n    <= ~cpu_we;
                        ram_ce_n    <= 1'b0;
                        grant       <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ACCESS;
                        starve_cnt  <= '0;
                    end else begin
                        starve_cnt <= '0;
                    end
                end

                // The RAM writes on this closing edge; reads capture ram_do here.
                // ram_we_n still holds the transaction direction at this point.
                ACCESS: begin
                    ram_ce_n <= 1'b1;
                    ram_we_n <= 1'b1;
                    state    <= ACK;
                    if (grant) begin
                        dma_ack <= 1'b1;
                        if (ram_we_n) begin
                            dma_rdata <= ram_do;
                        end
                    end else begin
                        cpu_ack <= 1'b1;
                        if (ram_we_n) begin
                            cpu_rdata <= ram_do;
                        end
                    end
                end

                ACK: begin
                    if (!winner_req) begin
                        cpu_ack <= 1'b0;
                        dma_ack <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Self-checking bench for ram_arbiter. Provides a 16kx16 byte-lane RAM model
//   behind the arbiter and a byte-array reference memory that predicts read data.
//   Covers reset values, a table of CPU transactions, randomized single
//   transactions, arbitration order, starvation limit, early req drop and
//   reset during a DMA write.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpuReq, cpuWe, cpuByte;
    logic [15:0] cpuAddr, cpuWdata;
    logic        cpuAck;
    logic [15:0] cpuRdata;
    logic        dmaReq, dmaWe, dmaByte;
    logic [15:0] dmaAddr, dmaWdata;
    logic        dmaAck;
    logic [15:0] dmaRdata;
    logic [15:0] ramA, ramDi, ramDo;
    logic        ramCeN, ramWeN, ramByteOp, grant, busy;

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpuReq), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
        .cpu_we(cpuWe), .cpu_byte(cpuByte), .cpu_ack(cpuAck), .cpu_rdata(cpuRdata),
        .dma_req(dmaReq), .dma_addr(dmaAddr), .dma_wdata(dmaWdata),
        .dma_we(dmaWe), .dma_byte(dmaByte), .dma_ack(dmaAck), .dma_rdata(dmaRdata),
        .ram_a(ramA), .ram_di(ramDi), .ram_do(ramDo),
        .ram_ce_n(ramCeN), .ram_we_n(ramWeN), .ram_byte_op(ramByteOp),
        .grant(grant), .busy(busy)
    );

    // RAM model: odd byte lives in the high lane, byte reads return {0, byte}.
    logic [15:0] mem [0:16383];
    logic [13:0] memIdx;
    assign memIdx = ramA[14:1];
    assign ramDo  = ramByteOp ? {8'h00, (ramA[0] ? mem[memIdx][15:8] : mem[memIdx][7:0])}
                              : mem[memIdx];

    always @(posedge clk) begin
        if (!ramCeN && !ramWeN) begin
            if (!ramByteOp)   mem[memIdx] = ramDi;
            else if (ramA[0]) mem[memIdx][15:8] = ramDi[7:0];
            else              mem[memIdx][7:0] = ramDi[7:0];
        end
    end

    // Reference memory as plain bytes.
    logic [7:0] refMem [0:32767];

    function automatic logic [15:0] modelRead(input logic [15:0] a, input bit b);
        logic [14:0] ia;
        ia = a[14:0];
        if (b) return {8'h00, refMem[ia]};
        return {refMem[{ia[14:1], 1'b1}], refMem[{ia[14:1], 1'b0}]};
    endfunction

    task automatic modelWrite(input logic [15:0] a, input bit b, input logic [15:0] d);
        logic [14:0] ia;
        ia = a[14:0];
        if (b) begin
            refMem[ia] = d[7:0];
        end else begin
            refMem[{ia[14:1], 1'b0}] = d[7:0];
            refMem[{ia[14:1], 1'b1}] = d[15:8];
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit who, input bit req, input bit we, input bit byteOp,
                                 input logic [15:0] addr, input logic [15:0] wdata);
        if (who) begin
            dmaReq = req; dmaWe = we; dmaByte = byteOp; dmaAddr = addr; dmaWdata = wdata;
        end else begin
            cpuReq = req; cpuWe = we; cpuByte = byteOp; cpuAddr = addr; cpuWdata = wdata;
        end
    endtask

    task automatic waitAck(input bit who, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 40) begin
            @(posedge clk); #1;
            n++;
            ok = who ? dmaAck : cpuAck;
        end
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((busy || cpuAck || dmaAck) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("idle_reached", {31'b0, busy || cpuAck || dmaAck}, 0);
    endtask

    // One complete handshake from an idle arbiter with no competing request.
    task automatic doTrans(input bit who, input bit we, input bit byteOp,
                           input logic [15:0] addr, input logic [15:0] wdata,
                           output logic [15:0] rdata);
        int  cyc;
        int  weLow;
        bit  got;
        applyStimulus(who, 1'b1, we, byteOp, addr, wdata);
        cyc = 0; weLow = 0; got = 1'b0;
        while (!got && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (!ramWeN) weLow++;
            got = who ? dmaAck : cpuAck;
        end
        checkOutput("ack_latency", cyc, 2);
        checkOutput("we_pulse_cycles", weLow, we ? 1 : 0);
        checkOutput("grant_owner", {31'b0, grant}, {31'b0, who});
        rdata = who ? dmaRdata : cpuRdata;
        applyStimulus(who, 1'b0, we, byteOp, addr, wdata);
        @(posedge clk); #1;
        checkOutput("ack_fall", {31'b0, who ? dmaAck : cpuAck}, 0);
        checkOutput("busy_after", {31'b0, busy}, 0);
    endtask

    // Invariants checked every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("one_ack_only", {31'b0, cpuAck && dmaAck}, 0);
            checkOutput("ce_only_when_busy", {31'b0, !ramCeN && !busy}, 0);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        bit          we;
        bit          byteOp;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] expRdata;
    } vec_t;

    initial begin
        vec_t        vecs [8];
        logic [15:0] rd;
        logic [15:0] lastRd [2];
        logic [15:0] exp;
        bit          ok;
        bit          who, we, byteOp;
        logic [15:0] addr, wdata;
        int          dmaGrants;
        int          rounds;
        int          roundCnt [2];
        int          n;

        for (int i = 0; i < 16384; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 32768; i++) refMem[i] = 8'h00;

        // CPU table; writes expect rdata to keep the last read value.
        vecs[0] = '{1'b1, 1'b0, 16'h0140, 16'h1234, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 16'h0140, 16'h0000, 16'h1234};
        vecs[2] = '{1'b1, 1'b1, 16'h0141, 16'h00AB, 16'h1234};
        vecs[3] = '{1'b0, 1'b0, 16'h0140, 16'h0000, 16'hAB34};
        vecs[4] = '{1'b0, 1'b1, 16'h0141, 16'h0000, 16'h00AB};
        vecs[5] = '{1'b0, 1'b1, 16'h0140, 16'h0000, 16'h0034};
        vecs[6] = '{1'b1, 1'b1, 16'h0140, 16'h5566, 16'h0034};
        vecs[7] = '{1'b0, 1'b0, 16'h0140, 16'h0000, 16'hAB66};

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        #12;
        checkOutput("rst_cpu_ack", {31'b0, cpuAck}, 0);
        checkOutput("rst_dma_ack", {31'b0, dmaAck}, 0);
        checkOutput("rst_ce_n", {31'b0, ramCeN}, 1);
        checkOutput("rst_we_n", {31'b0, ramWeN}, 1);
        checkOutput("rst_ram_a", {16'b0, ramA}, 0);
        checkOutput("rst_ram_di", {16'b0, ramDi}, 0);
        checkOutput("rst_byte_op", {31'b0, ramByteOp}, 0);
        checkOutput("rst_grant", {31'b0, grant}, 0);
        checkOutput("rst_busy", {31'b0, busy}, 0);
        checkOutput("rst_cpu_rdata", {16'b0, cpuRdata}, 0);
        checkOutput("rst_dma_rdata", {16'b0, dmaRdata}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven CPU transactions.
        for (int i = 0; i < 8; i++) begin
            doTrans(1'b0, vecs[i].we, vecs[i].byteOp, vecs[i].addr, vecs[i].wdata, rd);
            checkOutput($sformatf("table_rdata_%0d", i), {16'b0, rd}, {16'b0, vecs[i].expRdata});
            if (vecs[i].we) modelWrite(vecs[i].addr, vecs[i].byteOp, vecs[i].wdata);
        end

        // Randomized single transactions against the reference memory.
        lastRd[0] = 16'hAB66;
        lastRd[1] = 16'h0000;
        for (int i = 0; i < 40; i++) begin
            who    = 1'($urandom_range(0, 1));
            we     = 1'($urandom_range(0, 1));
            byteOp = 1'($urandom_range(0, 1));
            addr   = 16'h0140 + 16'($urandom_range(0, 31));
            wdata  = 16'($urandom);
            doTrans(who, we, byteOp, addr, wdata, rd);
            if (we) begin
                checkOutput("rand_rdata_hold", {16'b0, rd}, {16'b0, lastRd[who]});
                modelWrite(addr, byteOp, wdata);
            end else begin
                exp = modelRead(addr, byteOp);
                checkOutput("rand_read", {16'b0, rd}, {16'b0, exp});
                lastRd[who] = exp;
            end
        end

        // Simultaneous requests: DMA first, then CPU.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0140, 16'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'h0141, 16'h0);
        waitAck(1'b1, ok);
        checkOutput("t3_dma_ack", {31'b0, ok}, 1);
        checkOutput("t3_dma_grant", {31'b0, grant}, 1);
        checkOutput("t3_cpu_waits", {31'b0, cpuAck}, 0);
        checkOutput("t3_dma_rdata", {16'b0, dmaRdata}, {16'b0, modelRead(16'h0141, 1'b1)});
        dmaReq = 1'b0;
        waitAck(1'b0, ok);
        checkOutput("t3_cpu_ack", {31'b0, ok}, 1);
        checkOutput("t3_cpu_grant", {31'b0, grant}, 0);
        checkOutput("t3_cpu_rdata", {16'b0, cpuRdata}, {16'b0, modelRead(16'h0140, 1'b0)});
        cpuReq = 1'b0;
        waitIdle();

        // Back-to-back DMA with CPU pending: two rounds, each 4 DMA then CPU.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0142, 16'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0144, 16'h0);
        dmaGrants = 0; rounds = 0; n = 0;
        roundCnt[0] = -1; roundCnt[1] = -1;
        while (rounds < 2 && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (dmaAck && dmaReq) begin
                dmaReq = 1'b0;
                dmaGrants++;
            end else if (!dmaAck && !dmaReq) begin
                dmaReq = 1'b1;
            end
            if (cpuAck && cpuReq) begin
                cpuReq = 1'b0;
                roundCnt[rounds] = dmaGrants;
                dmaGrants = 0;
                rounds++;
            end else if (!cpuAck && !cpuReq) begin
                cpuReq = 1'b1;
            end
        end
        checkOutput("t4_round1_dma_grants", roundCnt[0], 4);
        checkOutput("t4_round2_dma_grants", roundCnt[1], 4);
        cpuReq = 1'b0;
        dmaReq = 1'b0;
        waitIdle();

        // CPU drops req during ACCESS; pending DMA follows straight after.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0150, 16'hBEEF);
        modelWrite(16'h0150, 1'b0, 16'hBEEF);
        @(posedge clk); #1;
        checkOutput("t6_in_access", {31'b0, ramCeN}, 0);
        cpuReq = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0150, 16'h0);
        @(posedge clk); #1;
        checkOutput("t6_ack_high", {31'b0, cpuAck}, 1);
        @(posedge clk); #1;
        checkOutput("t6_ack_low", {31'b0, cpuAck}, 0);
        checkOutput("t6_idle", {31'b0, busy}, 0);
        @(posedge clk); #1;
        checkOutput("t6_dma_busy", {31'b0, busy}, 1);
        checkOutput("t6_dma_grant", {31'b0, grant}, 1);
        checkOutput("t6_dma_ce", {31'b0, ramCeN}, 0);
        waitAck(1'b1, ok);
        checkOutput("t6_dma_ack", {31'b0, ok}, 1);
        checkOutput("t6_dma_rdata", {16'b0, dmaRdata}, 32'h0000BEEF);
        dmaReq = 1'b0;
        waitIdle();

        // Reset in the middle of a DMA write: write is abandoned.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0200, 16'hFFFF);
        @(posedge clk); #1;
        checkOutput("t5_write_started", {31'b0, ramWeN}, 0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t5_we_n_async", {31'b0, ramWeN}, 1);
        checkOutput("t5_ce_n_async", {31'b0, ramCeN}, 1);
        checkOutput("t5_idle", {31'b0, busy}, 0);
        checkOutput("t5_dma_ack", {31'b0, dmaAck}, 0);
        dmaReq = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("t5_dma_ack_after", {31'b0, dmaAck}, 0);
        checkOutput("t5_mem_model", {16'b0, modelRead(16'h0200, 1'b0)}, 0);
        doTrans(1'b0, 1'b0, 1'b0, 16'h0200, 16'h0, rd);
        checkOutput("t5_mem_unchanged", {16'b0, rd}, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
